// File: rtl/axis_cfg_seq.sv
// -----------------------------------------------------------------------------
// axis_cfg_seq
//
// Configuration-bus sequencer for the stream read/write engines. Descriptors
// {id, start address, length} are accepted through a valid/ready handshake,
// queued in a small FIFO, and replayed onto the one-cycle cfg bus as three
// words: id on CFG_ADDR, then address and length on CFG_DATA. GAP idle cycles
// separate the words of one descriptor, and HOLD idle cycles (plus one IDLE
// cycle) separate consecutive descriptors.
//
// Optional feature macro: AXIS_CFG_SEQ_COUNT_EN
//   defined   -> desc_count counts DATA1 words (16-bit, wrapping)
//   undefined -> desc_count is tied to zero
//
// Ports
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   cmd_id       in   target engine id              (CFG_DWIDTH)
//   cmd_address  in   stream start address          (CFG_DWIDTH)
//   cmd_length   in   stream length                 (CFG_DWIDTH)
//   cmd_valid    in   descriptor valid
//   cmd_ready    out  descriptor FIFO not full
//   cfg_addr     out  cfg bus address               (CFG_AWIDTH)
//   cfg_data     out  cfg bus data                  (CFG_DWIDTH)
//   cfg_valid    out  cfg bus strobe, one cycle per word
//   busy         out  FIFO non-empty or sequencer active (registered)
//   desc_count   out  descriptors fully issued      (16)
// -----------------------------------------------------------------------------
module axis_cfg_seq #(
    parameter int CFG_AWIDTH   = 5,
    parameter int CFG_DWIDTH   = 32,
    parameter int CFG_ADDR     = 23,
    parameter int CFG_DATA     = 24,
    parameter int GAP          = 1,
    parameter int HOLD         = 4,
    parameter int QUEUE_AWIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CFG_DWIDTH-1:0] cmd_id,
    input  logic [CFG_DWIDTH-1:0] cmd_address,
    input  logic [CFG_DWIDTH-1:0] cmd_length,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic                  cfg_valid,
    output logic                  busy,
    output logic [15:0]           desc_count
);

    localparam int DEPTH  = 1 << QUEUE_AWIDTH;
    localparam int DESC_W = 3 * CFG_DWIDTH;

    localparam logic [CFG_AWIDTH-1:0] SEL_ADDR = CFG_AWIDTH'(CFG_ADDR);
    localparam logic [CFG_AWIDTH-1:0] SEL_DATA = CFG_AWIDTH'(CFG_DATA);

    // Wait counters are loaded with N-1 and leave the wait state at zero,
    // giving exactly N idle cycles. Unused when the matching count is 0.
    localparam logic [7:0] GAP_LD  = 8'(GAP - 1);
    localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP_A,
        S_DATA0,
        S_GAP_B,
        S_DATA1,
        S_HOLD
    } state_e;

    // -------------------------------------------------------------------------
    // Descriptor FIFO
    // -------------------------------------------------------------------------
    logic [DESC_W-1:0]       mem_q [DEPTH];
    logic [QUEUE_AWIDTH-1:0] wr_ptr_q;
    logic [QUEUE_AWIDTH-1:0] rd_ptr_q;
    logic [QUEUE_AWIDTH:0]   count_q;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [DESC_W-1:0]       head;

    state_e                  state_q;
    state_e                  state_d;

    // count_q never exceeds DEPTH, so its MSB is set only when full.
    assign full      = count_q[QUEUE_AWIDTH];
    assign empty     = (count_q == '0);
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    // Pop only from the registered count: a descriptor pushed this cycle is
    // not visible to the sequencer until the next one.
    assign pop       = (state_q == S_IDLE) & ~empty;
    assign head      = mem_q[rd_ptr_q];

    // NOTE: storage arrays carry no reset; the pointers and count define
    // which entries are valid, so clearing the data itself buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_id, cmd_address, cmd_length};
        end
    end

    // -------------------------------------------------------------------------
    // Active descriptor: address and length are replayed after the id word.
    // Loaded only on pop, so no reset is needed here either.
    // -------------------------------------------------------------------------
    logic [CFG_DWIDTH-1:0] addr_q;
    logic [CFG_DWIDTH-1:0] len_q;

    always_ff @(posedge clk) begin
        if (pop) begin
            addr_q <= head[2*CFG_DWIDTH-1 -: CFG_DWIDTH];
            len_q  <= head[CFG_DWIDTH-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    logic [7:0]            cnt_q;
    logic [7:0]            cnt_d;
    logic                  cfg_valid_q;
    logic                  cfg_valid_d;
    logic [CFG_AWIDTH-1:0] cfg_addr_q;
    logic [CFG_AWIDTH-1:0] cfg_addr_d;
    logic [CFG_DWIDTH-1:0] cfg_data_q;
    logic [CFG_DWIDTH-1:0] cfg_data_d;
    logic                  busy_q;

    // cfg outputs are computed from the transition into a word state, so the
    // registered strobe is high in exactly the cycle the FSM sits in that state.
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_valid_d = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d     = S_ADDR;
                    cfg_valid_d = 1'b1;
                    cfg_addr_d  = SEL_ADDR;
                    cfg_data_d  = head[DESC_W-1 -: CFG_DWIDTH];
                end
            end
            S_ADDR: begin
                if (GAP == 0) begin
                    state_d     = S_DATA0;
                    cfg_valid_d = 1'b1;
                    cfg_addr_d  = SEL_DATA;
                    cfg_data_d  = addr_q;
                end else begin
                    state_d = S_GAP_A;
                    cnt_d   = GAP_LD;
                end
            end
            S_GAP_A: begin
                if (cnt_q == '0) begin
                    state_d     = S_DATA0;
                    cfg_valid_d = 1'b1;
                    cfg_addr_d  = SEL_DATA;
                    cfg_data_d  = addr_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA0: begin
                if (GAP == 0) begin
                    state_d     = S_DATA1;
                    cfg_valid_d = 1'b1;
                    cfg_addr_d  = SEL_DATA;
                    cfg_data_d  = len_q;
                end else begin
                    state_d = S_GAP_B;
                    cnt_d   = GAP_LD;
                end
            end
            S_GAP_B: begin
                if (cnt_q == '0) begin
                    state_d     = S_DATA1;
                    cfg_valid_d = 1'b1;
                    cfg_addr_d  = SEL_DATA;
                    cfg_data_d  = len_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA1: begin
                if (HOLD == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            busy_q      <= (state_q != S_IDLE) || !empty;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign cfg_valid = cfg_valid_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_data  = cfg_data_q;
    assign busy      = busy_q;

    // -------------------------------------------------------------------------
    // Issued-descriptor counter
    // -------------------------------------------------------------------------
`ifdef AXIS_CFG_SEQ_COUNT_EN
    logic [15:0] desc_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            desc_count_q <= '0;
        end else if (state_q == S_DATA1) begin
            desc_count_q <= desc_count_q + 16'd1;
        end
    end

    assign desc_count = desc_count_q;
`else
    assign desc_count = '0;
`endif

endmodule

// File: tb/tb_axis_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_axis_cfg_seq
//
// Two sequencer instances: u_a (GAP=1, HOLD=4) and u_b (GAP=0, HOLD=0).
// Expected cfg words, tagged with the cycle they must appear in, are queued
// when descriptors are driven; a per-instance monitor pops and compares them
// whenever cfg_valid is seen. Cycle N is the clock period in which cyc == N.
// -----------------------------------------------------------------------------
module tb_axis_cfg_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

`ifdef AXIS_CFG_SEQ_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          at;
    } word_t;

    word_t a_q[$];
    word_t b_q[$];

    logic        rst_n;

    logic [31:0] a_cmd_id, a_cmd_address, a_cmd_length;
    logic        a_cmd_valid, a_cmd_ready;
    logic [4:0]  a_cfg_addr;
    logic [31:0] a_cfg_data;
    logic        a_cfg_valid, a_busy;
    logic [15:0] a_desc_count;

    logic [31:0] b_cmd_id, b_cmd_address, b_cmd_length;
    logic        b_cmd_valid, b_cmd_ready;
    logic [4:0]  b_cfg_addr;
    logic [31:0] b_cfg_data;
    logic        b_cfg_valid, b_busy;
    logic [15:0] b_desc_count;

    axis_cfg_seq #(
        .CFG_AWIDTH(5), .CFG_DWIDTH(32), .CFG_ADDR(23), .CFG_DATA(24),
        .GAP(1), .HOLD(4), .QUEUE_AWIDTH(2)
    ) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_id     (a_cmd_id),
        .cmd_address(a_cmd_address),
        .cmd_length (a_cmd_length),
        .cmd_valid  (a_cmd_valid),
        .cmd_ready  (a_cmd_ready),
        .cfg_addr   (a_cfg_addr),
        .cfg_data   (a_cfg_data),
        .cfg_valid  (a_cfg_valid),
        .busy       (a_busy),
        .desc_count (a_desc_count)
    );

    axis_cfg_seq #(
        .CFG_AWIDTH(5), .CFG_DWIDTH(32), .CFG_ADDR(23), .CFG_DATA(24),
        .GAP(0), .HOLD(0), .QUEUE_AWIDTH(2)
    ) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_id     (b_cmd_id),
        .cmd_address(b_cmd_address),
        .cmd_length (b_cmd_length),
        .cmd_valid  (b_cmd_valid),
        .cmd_ready  (b_cmd_ready),
        .cfg_addr   (b_cfg_addr),
        .cfg_data   (b_cfg_data),
        .cfg_valid  (b_cfg_valid),
        .busy       (b_busy),
        .desc_count (b_desc_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
        return CNT_EN ? 16'(n) : 16'd0;
    endfunction

    // Advance to 1 time unit after the edge that starts cycle n.
    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Move to the falling edge inside cycle n, away from the active edge.
    task automatic sample(input int n);
        wait_cyc(n);
        @(negedge clk);
    endtask

    task automatic expect_word(input bit to_b, input logic [4:0] addr,
                               input logic [31:0] data, input int at);
        word_t w;
        w.addr = addr;
        w.data = data;
        w.at   = at;
        if (to_b) b_q.push_back(w);
        else      a_q.push_back(w);
    endtask

    task automatic expect_desc(input bit to_b, input logic [31:0] id,
                               input logic [31:0] addr, input logic [31:0] len,
                               input int t0, input int gap);
        expect_word(to_b, 5'd23, id,   t0);
        expect_word(to_b, 5'd24, addr, t0 + gap + 1);
        expect_word(to_b, 5'd24, len,  t0 + 2 * gap + 2);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (a_cfg_valid === 1'b1) begin
            word_t w;
            total++;
            assert (a_q.size() > 0) else begin
                bad++;
                $error("FAIL a_spurious_word cycle=%0d observed=(%0d,0x%0h) expected=none",
                       cyc, a_cfg_addr, a_cfg_data);
            end
            if (a_q.size() > 0) begin
                w = a_q.pop_front();
                check("a_word", {27'd0, a_cfg_addr, a_cfg_data}, {27'd0, w.addr, w.data});
                check("a_word_cycle", 64'(cyc), 64'(w.at));
            end
        end
    end

    always @(negedge clk) begin
        if (b_cfg_valid === 1'b1) begin
            word_t w;
            total++;
            assert (b_q.size() > 0) else begin
                bad++;
                $error("FAIL b_spurious_word cycle=%0d observed=(%0d,0x%0h) expected=none",
                       cyc, b_cfg_addr, b_cfg_data);
            end
            if (b_q.size() > 0) begin
                w = b_q.pop_front();
                check("b_word", {27'd0, b_cfg_addr, b_cfg_data}, {27'd0, w.addr, w.data});
                check("b_word_cycle", 64'(cyc), 64'(w.at));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog cycle=%0d observed=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        a_cmd_valid   = 1'b0;
        a_cmd_id      = '0;
        a_cmd_address = '0;
        a_cmd_length  = '0;
        b_cmd_valid   = 1'b0;
        b_cmd_id      = '0;
        b_cmd_address = '0;
        b_cmd_length  = '0;

        wait_cyc(3);
        rst_n = 1'b1;

        // Reset state
        sample(5);
        check("rst_cmd_ready",  64'(a_cmd_ready),  64'd1);
        check("rst_cfg_valid",  64'(a_cfg_valid),  64'd0);
        check("rst_cfg_addr",   64'(a_cfg_addr),   64'd0);
        check("rst_cfg_data",   64'(a_cfg_data),   64'd0);
        check("rst_busy",       64'(a_busy),       64'd0);
        check("rst_desc_count", 64'(a_desc_count), 64'd0);
        check("rst_b_ready",    64'(b_cmd_ready),  64'd1);
        check("rst_b_busy",     64'(b_busy),       64'd0);

        // Single descriptor: words at 12, 14, 16; busy falls at 22
        wait_cyc(10);
        a_cmd_id      = 32'd1;
        a_cmd_address = 32'h1000_0000;
        a_cmd_length  = 32'h40;
        a_cmd_valid   = 1'b1;
        expect_desc(1'b0, 32'd1, 32'h1000_0000, 32'h40, 12, 1);
        wait_cyc(11);
        a_cmd_valid = 1'b0;
        sample(12);
        check("single_busy_12", 64'(a_busy), 64'd1);
        sample(13);
        check("gap_valid_low", 64'(a_cfg_valid), 64'd0);
        check("gap_addr_held", 64'(a_cfg_addr),  64'd23);
        check("gap_data_held", 64'(a_cfg_data),  64'd1);
        sample(17);
        check("hold_valid_low", 64'(a_cfg_valid), 64'd0);
        check("hold_addr_held", 64'(a_cfg_addr),  64'd24);
        check("hold_data_held", 64'(a_cfg_data),  64'h40);
        sample(21);
        check("single_busy_21", 64'(a_busy), 64'd1);
        sample(22);
        check("single_busy_22", 64'(a_busy), 64'd0);
        check("single_count",   64'(a_desc_count), 64'(exp_cnt(1)));

        // Back-to-back: one descriptor starts, then five more fill the FIFO.
        // At full throughput ADDR words fall every 10 cycles from cycle 32.
        wait_cyc(30);
        a_cmd_id      = 32'd16;
        a_cmd_address = 32'hA000_0000;
        a_cmd_length  = 32'h10;
        a_cmd_valid   = 1'b1;
        expect_desc(1'b0, 32'd16, 32'hA000_0000, 32'h10, 32, 1);
        wait_cyc(31);
        a_cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            wait_cyc(31 + k);
            a_cmd_id      = 32'(16 + k);
            a_cmd_address = 32'hA000_0000 + 32'(k * 256);
            a_cmd_length  = 32'h10 + 32'(k);
            a_cmd_valid   = 1'b1;
            expect_desc(1'b0, 32'(16 + k), 32'hA000_0000 + 32'(k * 256),
                        32'h10 + 32'(k), 32 + 10 * k, 1);
        end
        sample(35);
        check("fill_ready_3", 64'(a_cmd_ready), 64'd1);
        wait_cyc(36);
        a_cmd_id      = 32'd21;
        a_cmd_address = 32'hA000_0500;
        a_cmd_length  = 32'h15;
        expect_desc(1'b0, 32'd21, 32'hA000_0500, 32'h15, 82, 1);
        sample(36);
        check("full_ready_low", 64'(a_cmd_ready), 64'd0);
        sample(41);
        check("full_ready_pop_cycle", 64'(a_cmd_ready), 64'd0);
        sample(42);
        check("ready_after_pop", 64'(a_cmd_ready), 64'd1);
        wait_cyc(43);
        a_cmd_valid = 1'b0;
        sample(43);
        check("refull_ready_low", 64'(a_cmd_ready), 64'd0);
        sample(91);
        check("b2b_busy_91", 64'(a_busy), 64'd1);
        sample(92);
        check("b2b_busy_92", 64'(a_busy), 64'd0);
        check("b2b_count",   64'(a_desc_count), 64'(exp_cnt(7)));

        // GAP=0, HOLD=0: words at 112..114, next ADDR at 116
        wait_cyc(110);
        b_cmd_id      = 32'd3;
        b_cmd_address = 32'hB000_0000;
        b_cmd_length  = 32'h20;
        b_cmd_valid   = 1'b1;
        expect_desc(1'b1, 32'd3, 32'hB000_0000, 32'h20, 112, 0);
        wait_cyc(111);
        b_cmd_id      = 32'd4;
        b_cmd_address = 32'hB000_1000;
        b_cmd_length  = 32'h30;
        expect_desc(1'b1, 32'd4, 32'hB000_1000, 32'h30, 116, 0);
        wait_cyc(112);
        b_cmd_valid = 1'b0;
        sample(115);
        check("b_idle_valid_low", 64'(b_cfg_valid), 64'd0);
        check("b_idle_data_held", 64'(b_cfg_data),  64'h20);
        sample(119);
        check("b_busy_119", 64'(b_busy), 64'd1);
        sample(120);
        check("b_busy_120", 64'(b_busy), 64'd0);
        check("b_count",    64'(b_desc_count), 64'(exp_cnt(2)));

        // Reset after the DATA0 pulse with two descriptors still queued
        wait_cyc(130);
        a_cmd_id      = 32'd7;
        a_cmd_address = 32'hC000_0000;
        a_cmd_length  = 32'h70;
        a_cmd_valid   = 1'b1;
        expect_word(1'b0, 5'd23, 32'd7, 132);
        expect_word(1'b0, 5'd24, 32'hC000_0000, 134);
        wait_cyc(131);
        a_cmd_id      = 32'd8;
        a_cmd_address = 32'hC000_1000;
        wait_cyc(132);
        a_cmd_id      = 32'd9;
        a_cmd_address = 32'hC000_2000;
        wait_cyc(133);
        a_cmd_valid = 1'b0;
        wait_cyc(135);
        rst_n = 1'b0;
        wait_cyc(136);
        rst_n = 1'b1;
        sample(137);
        check("mid_rst_ready",     64'(a_cmd_ready),  64'd1);
        check("mid_rst_busy",      64'(a_busy),       64'd0);
        check("mid_rst_cfg_addr",  64'(a_cfg_addr),   64'd0);
        check("mid_rst_cfg_data",  64'(a_cfg_data),   64'd0);
        check("mid_rst_count",     64'(a_desc_count), 64'd0);
        for (int i = 138; i < 148; i++) begin
            sample(i);
            check("mid_rst_quiet", 64'(a_cfg_valid), 64'd0);
        end

        sample(150);
        check("a_scoreboard_drained", 64'(a_q.size()), 64'd0);
        check("b_scoreboard_drained", 64'(b_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
